// File: rtl/md5_msg_sequencer.sv
// md5_msg_sequencer
//   Front-end controller for md5_chunk_cruncher. Packs a stream of 32-bit
//   little-endian message words into a 16-word chunk buffer, appends MD5
//   padding and the 64-bit bit length, starts the cruncher once per chunk
//   and returns the final 128-bit digest on a valid/ready output.
//
// Ports
//   clk, reset          clock; synchronous active-low reset (0 = reset)
//   in_valid/in_ready   message word handshake
//   in_data             message word, byte 0 in bits [7:0]
//   in_last, in_nbytes  final word marker; valid bytes in final word (0 = 4)
//   crunch_init         cruncher reset / IV reload (active-high)
//   crunch_start        one-cycle start pulse per chunk
//   crunch_done         cruncher finished the current chunk
//   crunch_gaddr        cruncher word address into the chunk buffer
//   crunch_mdata        chunk buffer word at crunch_gaddr (combinational)
//   crunch_digest       running cruncher digest {d0,c0,b0,a0}
//   digest_valid/ready  digest output handshake
//   digest              registered final digest
module md5_msg_sequencer (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_nbytes,
    output logic         crunch_init,
    output logic         crunch_start,
    input  logic         crunch_done,
    input  logic [3:0]   crunch_gaddr,
    output logic [31:0]  crunch_mdata,
    input  logic [127:0] crunch_digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [127:0] digest
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_PAD   = 3'd2;
    localparam logic [2:0] S_LEN   = 3'd3;
    localparam logic [2:0] S_START = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_OUT   = 3'd6;

    logic [2:0]   state_q, state_d;
    logic [2:0]   resume_q, resume_d;
    logic [3:0]   widx_q, widx_d;
    logic [63:0]  len_q, len_d;
    logic         pad_pending_q, pad_pending_d;
    logic         final_q, final_d;
    logic [127:0] digest_q, digest_d;
    logic [31:0]  buf_q [16];

    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         len_wr;

    logic [2:0]   nb_eff;
    logic [4:0]   tail_bits;
    logic [31:0]  tail_mask;
    logic [31:0]  tail_marker;

    // Byte count of the final word: encoding 0 stands for a full word.
    assign nb_eff      = (in_nbytes == 2'd0) ? 3'd4 : {1'b0, in_nbytes};
    assign tail_bits   = {in_nbytes, 3'b000};
    assign tail_mask   = ~(32'hFFFF_FFFF << tail_bits);
    assign tail_marker = 32'h0000_0080 << tail_bits;

    always_comb begin
        state_d       = state_q;
        resume_d      = resume_q;
        widx_d        = widx_q;
        len_d         = len_q;
        pad_pending_d = pad_pending_q;
        final_d       = final_q;
        digest_d      = digest_q;
        wr_en         = 1'b0;
        wr_addr       = widx_q;
        wr_data       = '0;
        len_wr        = 1'b0;

        case (state_q)
            S_INIT: begin
                widx_d        = '0;
                len_d         = '0;
                pad_pending_d = 1'b0;
                final_d       = 1'b0;
                state_d       = S_FILL;
            end
            S_FILL: begin
                if (in_valid) begin
                    wr_en  = 1'b1;
                    widx_d = widx_q + 4'd1;
                    if (!in_last) begin
                        wr_data  = in_data;
                        len_d    = len_q + 64'd32;
                        resume_d = S_FILL;
                        if (widx_q == 4'd15) state_d = S_START;
                    end else begin
                        len_d = len_q + {58'd0, nb_eff, 3'b000};
                        if (nb_eff == 3'd4) begin
                            // Full final word: the 0x80 marker goes into the next word.
                            wr_data       = in_data;
                            pad_pending_d = 1'b1;
                        end else begin
                            wr_data = (in_data & tail_mask) | tail_marker;
                        end
                        if (widx_q == 4'd15) begin
                            resume_d = S_PAD;
                            state_d  = S_START;
                        end else begin
                            state_d  = S_PAD;
                        end
                    end
                end
            end
            S_PAD: begin
                if (widx_q == 4'd14 && !pad_pending_q) begin
                    state_d = S_LEN;
                end else begin
                    wr_en         = 1'b1;
                    wr_data       = pad_pending_q ? 32'h0000_0080 : 32'h0;
                    pad_pending_d = 1'b0;
                    widx_d        = widx_q + 4'd1;
                    // No room left for the length: flush this chunk and pad on.
                    if (widx_q == 4'd15) begin
                        resume_d = S_PAD;
                        state_d  = S_START;
                    end
                end
            end
            S_LEN: begin
                len_wr  = 1'b1;
                final_d = 1'b1;
                state_d = S_START;
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (crunch_done) begin
                    if (final_q) begin
                        digest_d = crunch_digest;
                        state_d  = S_OUT;
                    end else begin
                        widx_d  = '0;
                        state_d = resume_q;
                    end
                end
            end
            S_OUT: begin
                if (digest_ready) state_d = S_INIT;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_INIT;
            resume_q      <= S_FILL;
            widx_q        <= '0;
            len_q         <= '0;
            pad_pending_q <= 1'b0;
            final_q       <= 1'b0;
            digest_q      <= '0;
        end else begin
            state_q       <= state_d;
            resume_q      <= resume_d;
            widx_q        <= widx_d;
            len_q         <= len_d;
            pad_pending_q <= pad_pending_d;
            final_q       <= final_d;
            digest_q      <= digest_d;
        end
    end

    // Chunk buffer holds no reset value; its contents are rewritten per chunk.
    always_ff @(posedge clk) begin
        if (wr_en) buf_q[wr_addr] <= wr_data;
        if (len_wr) begin
            buf_q[14] <= len_q[31:0];
            buf_q[15] <= len_q[63:32];
        end
    end

    assign in_ready     = (state_q == S_FILL);
    assign crunch_init  = (state_q == S_INIT);
    assign crunch_start = (state_q == S_START);
    assign digest_valid = (state_q == S_OUT);
    assign digest       = digest_q;
    assign crunch_mdata = buf_q[crunch_gaddr];

endmodule

// File: tb/tb_md5_msg_sequencer.sv
// Testbench for md5_msg_sequencer. Contains a behavioural MD5 cruncher that
// reads each served chunk, a software MD5 padding/digest model, and a monitor
// that checks handshake and stability rules on every cycle.
module tb_md5_msg_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [1:0]   in_nbytes;
    logic         crunch_init;
    logic         crunch_start;
    logic         crunch_done;
    logic [3:0]   crunch_gaddr;
    logic [31:0]  crunch_mdata;
    logic [127:0] crunch_digest;
    logic         digest_valid;
    logic         digest_ready;
    logic [127:0] digest;

    always #5 clk = ~clk;

    md5_msg_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_nbytes     (in_nbytes),
        .crunch_init   (crunch_init),
        .crunch_start  (crunch_start),
        .crunch_done   (crunch_done),
        .crunch_gaddr  (crunch_gaddr),
        .crunch_mdata  (crunch_mdata),
        .crunch_digest (crunch_digest),
        .digest_valid  (digest_valid),
        .digest_ready  (digest_ready),
        .digest        (digest)
    );

    localparam logic [127:0] IV = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [127:0] ABC_DIGEST =
        {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

    int errors = 0;
    int checks = 0;
    int starts = 0;
    int cnt    = 0;

    logic [31:0]  kt [64];
    logic [7:0]   msg [$];
    logic [511:0] exp_chunks [$];
    logic [511:0] served [$];
    logic [127:0] exp_digest;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned shamt(input int unsigned i);
        logic [79:0] t;
        int unsigned idx;
        t = {5'd21, 5'd15, 5'd10, 5'd6, 5'd23, 5'd16, 5'd11, 5'd4,
             5'd20, 5'd14, 5'd9,  5'd5, 5'd22, 5'd17, 5'd12, 5'd7};
        idx = (i / 16) * 4 + (i % 4);
        return int'(t[idx*5 +: 5]);
    endfunction

    // One MD5 compression; state and result are {d,c,b,a}.
    function automatic logic [127:0] md5_block(input logic [127:0] st, input logic [511:0] m);
        logic [31:0] a, b, c, d, f;
        int unsigned g, s;
        a = st[31:0]; b = st[63:32]; c = st[95:64]; d = st[127:96];
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            s = shamt(i);
            f = f + a + kt[i] + m[g*32 +: 32];
            a = d; d = c; c = b;
            b = b + ((f << s) | (f >> (32 - s)));
        end
        return {d + st[127:96], c + st[95:64], b + st[63:32], a + st[31:0]};
    endfunction

    // Standard MD5 padding of msg into expected chunks and expected digest.
    task automatic build_expected(output int nchunks);
        logic [7:0]   p [$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        logic [127:0] st;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bitlen = 64'(msg.size()) * 64'd8;
        for (int b = 0; b < 8; b++) p.push_back(bitlen[b*8 +: 8]);
        exp_chunks.delete();
        st = IV;
        nchunks = p.size() / 64;
        for (int c = 0; c < nchunks; c++) begin
            for (int w = 0; w < 16; w++)
                blk[w*32 +: 32] = {p[c*64+w*4+3], p[c*64+w*4+2], p[c*64+w*4+1], p[c*64+w*4]};
            exp_chunks.push_back(blk);
            st = md5_block(st, blk);
        end
        exp_digest = st;
    endtask

    function automatic logic [31:0] sw(input int c, input int w);
        if (c < served.size()) return served[c][w*32 +: 32];
        return 'x;
    endfunction

    task automatic set_msg(input int len, input int seed);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'(i * 37 + seed));
    endtask

    // Behavioural cruncher: reads the 16 chunk words, compresses, pulses done.
    initial begin
        logic [511:0] blk;
        logic [511:0] e;
        logic [127:0] cst;
        crunch_done   = 1'b0;
        crunch_gaddr  = '0;
        crunch_digest = '0;
        cst           = IV;
        blk           = '0;
        forever begin
            @(posedge clk);
            #1;
            crunch_done = 1'b0;
            if (crunch_init) begin
                cst = IV;
                crunch_digest = IV;
                cnt = 0;
            end else if (cnt > 0) begin
                if (cnt <= 16) begin
                    crunch_gaddr = 4'(cnt - 1);
                    #1;
                    blk[(cnt-1)*32 +: 32] = crunch_mdata;
                    if (cnt == 16) begin
                        served.push_back(blk);
                        if (exp_chunks.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL extra chunk: got chunk %0d expected none", served.size());
                        end else begin
                            e = exp_chunks.pop_front();
                            for (int w = 0; w < 16; w++)
                                check($sformatf("chunk %0d word %0d", served.size() - 1, w),
                                      blk[w*32 +: 32], e[w*32 +: 32]);
                        end
                        cst = md5_block(cst, blk);
                        crunch_digest = cst;
                    end
                end
                if (cnt == 24) begin
                    crunch_done = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else if (crunch_start) begin
                cnt = 1;
            end
        end
    end

    // Per-cycle monitor: stall rules, start count, digest stability.
    initial begin
        logic         prev_dv;
        logic         prev_dr;
        logic [127:0] prev_dig;
        prev_dv = 1'b0; prev_dr = 1'b0; prev_dig = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (crunch_start) starts++;
                if (cnt > 0) check("in_ready while cruncher busy", in_ready, 0);
                if (digest_valid) begin
                    check("in_ready while digest_valid", in_ready, 0);
                    if (prev_dv && !prev_dr) check("digest stable", digest, prev_dig);
                end
                prev_dv = digest_valid; prev_dr = digest_ready; prev_dig = digest;
            end else begin
                prev_dv = 1'b0;
            end
        end
    end

    task automatic send_words(input int limit, input bit garbage);
        int nw, n;
        nw = (msg.size() + 3) / 4;
        n  = (limit < nw) ? limit : nw;
        for (int w = 0; w < n; w++) begin
            logic [31:0] d;
            bit ok;
            for (int b = 0; b < 4; b++)
                d[b*8 +: 8] = (w*4 + b < msg.size()) ? msg[w*4 + b] : (garbage ? 8'hA5 : 8'h00);
            in_data   = d;
            in_last   = (w == nw - 1);
            in_nbytes = 2'(msg.size() % 4);
            in_valid  = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 1000 && !ok; t++) begin
                @(negedge clk);
                ok = in_ready;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL handshake timeout word %0d: in_ready=0 required 1", w);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_msg(input bit garbage, input int bp_cycles);
        int  nch;
        bit  found;
        build_expected(nch);
        served.delete();
        starts = 0;
        send_words(1 << 20, garbage);
        found = 1'b0;
        for (int t = 0; t < 3000 && !found; t++) begin
            @(negedge clk);
            found = digest_valid;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL digest_valid timeout: got 0 expected 1");
            return;
        end
        check("digest vs model", digest, exp_digest);
        check("crunch_start count", starts, nch);
        @(posedge clk);
        #1;
        for (int i = 0; i < bp_cycles; i++) begin
            @(posedge clk);
            #1;
            check("digest_valid under backpressure", digest_valid, 1);
        end
        digest_ready = 1'b1;
        @(posedge clk);
        #1;
        digest_ready = 1'b0;
        check("crunch_init after digest", crunch_init, 1);
        check("digest_valid after handshake", digest_valid, 0);
        @(posedge clk);
        #1;
        check("crunch_init one cycle", crunch_init, 0);
        check("in_ready after INIT", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            real r;
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            kt[i] = 32'(longint'($floor(r * 4294967296.0)));
        end
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_nbytes = '0; digest_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset crunch_start", crunch_start, 0);
        check("reset digest_valid", digest_valid, 0);
        check("reset digest", digest, 0);
        check("reset crunch_init", crunch_init, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after first INIT", in_ready, 1);

        // "abc"
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(1'b0, 0);
        check("abc digest literal", digest, ABC_DIGEST);
        check("abc word0", sw(0, 0), 32'h80636261);
        check("abc word1", sw(0, 1), 32'h0);
        check("abc word14", sw(0, 14), 32'h18);
        check("abc word15", sw(0, 15), 32'h0);

        // 55 bytes: marker shares the final word, length fits in one chunk
        set_msg(55, 3);
        run_msg(1'b1, 0);
        check("55B word13 marker", sw(0, 13) >> 24, 32'h80);
        check("55B word14", sw(0, 14), 32'h1B8);

        // 56 bytes: length spills into a second chunk
        set_msg(56, 11);
        run_msg(1'b1, 0);
        check("56B c0 word14", sw(0, 14), 32'h80);
        check("56B c0 word15", sw(0, 15), 32'h0);
        check("56B c1 word0", sw(1, 0), 32'h0);
        check("56B c1 word14", sw(1, 14), 32'h1C0);

        // 64 bytes with digest backpressure
        set_msg(64, 29);
        run_msg(1'b0, 10);
        check("64B c1 word0", sw(1, 0), 32'h80);
        check("64B c1 word14", sw(1, 14), 32'h200);

        // 101 bytes: in_valid held across WAIT, words must not be lost
        set_msg(101, 5);
        run_msg(1'b1, 2);
        check("101B c1 word14", sw(1, 14), 32'h328);

        // Reset while the first chunk is being crunched
        set_msg(70, 17);
        exp_chunks.delete();
        send_words(16, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("abort crunch_init", crunch_init, 1);
        check("abort digest_valid", digest_valid, 0);
        check("abort in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("abort in_ready after INIT", in_ready, 1);
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(1'b0, 0);
        check("abc after abort digest literal", digest, ABC_DIGEST);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
